// File: rtl/ctrl_data_drain.sv
// ---------------------------------------------------------------------------
// ctrl_data_drain
//
// Read-side drain stage for ctrl_data_fifo. Pops paired {ctrl, data} entries
// whenever the FIFO is non-empty and the output buffer has a slot reserved
// for every entry already requested. Each pop is tracked through a
// READ_LATENCY-deep valid pipe, so fifo_dout is captured purely by latency
// position; the FIFO's own valid output is not needed. Captured entries go
// into a circular output buffer that is presented as a valid/ready stream.
// A single-cycle flush discards buffered and in-flight entries without
// touching the FIFO.
//
// Optional feature macro: CTRL_DATA_DRAIN_PKT_CNT_EN
//   When defined, pkt_count exists and counts accepted beats that carry
//   m_last=1 (wrapping). Flush leaves it alone; reset clears it.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fifo_dout      in   FIFO read data, {ctrl, data}
//   fifo_empty     in   FIFO empty (reflects a pop by the following cycle)
//   fifo_shift_out out  pop strobe to the FIFO
//   m_ctrl         out  head ctrl word (0 while the buffer is empty)
//   m_data         out  head data word (0 while the buffer is empty)
//   m_last         out  m_ctrl[0], packet-last flag
//   m_valid        out  head entry valid
//   m_ready        in   consumer accept
//   flush          in   single-cycle discard request
//   occupancy      out  number of buffered entries
//   busy           out  entries buffered or in flight, or flush in progress
//   pkt_count      out  accepted packets (macro builds only)
//
// Handshake: a beat transfers in any cycle where m_valid && m_ready are both
// high at the rising edge. Once m_valid is high it stays high, with m_ctrl,
// m_data and m_last held stable, until the beat transfers; only flush or
// reset may withdraw it.
// ---------------------------------------------------------------------------
module ctrl_data_drain #(
    parameter int DATA_WIDTH    = 32,
    parameter int CTRL_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int OUT_DEPTH     = 4,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0]     fifo_dout,
    input  logic                                 fifo_empty,
    output logic                                 fifo_shift_out,
    output logic [CTRL_WIDTH-1:0]                m_ctrl,
    output logic [DATA_WIDTH-1:0]                m_data,
    output logic                                 m_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    input  logic                                 flush,
    output logic [$clog2(OUT_DEPTH+1)-1:0]       occupancy,
    output logic                                 busy
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
    ,
    output logic [PKT_CNT_WIDTH-1:0]             pkt_count
`endif
);

    localparam int ENTRY_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCC_W   = $clog2(OUT_DEPTH + 1);
    localparam int INF_W   = $clog2(READ_LATENCY + 1);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    generate
        if (READ_LATENCY < 1) begin : g_bad_latency
            $error("ctrl_data_drain: READ_LATENCY must be >= 1");
        end
        if (OUT_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
            $error("ctrl_data_drain: OUT_DEPTH must be >= READ_LATENCY+1");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                     state_q,  state_d;
    logic [READ_LATENCY-1:0]    pipe_q,   pipe_d;   // bit i set: pop issued i+1 cycles ago
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]           occ_q,    occ_d;
    logic [ENTRY_W-1:0]         mem_q [OUT_DEPTH];  // storage only, not reset

`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
    logic [PKT_CNT_WIDTH-1:0]   pkt_q,    pkt_d;
`endif

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [INF_W-1:0]   inflight;
    logic               room;
    logic               pop;
    logic               wr_en;
    logic               rd_en;
    logic               buf_nonempty;
    logic [ENTRY_W-1:0] head;

    // Number of pops whose data has not yet been captured.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(pipe_q[i]);
        end
    end

    // A slot is reserved for every pop in flight. Acceptance in the current
    // cycle is deliberately not credited, so the pop decision only depends
    // on registered counts and fifo_empty.
    always_comb begin
        room = (int'(occ_q) + int'(inflight)) < OUT_DEPTH;
    end

    // rst_n gates the strobe so the FIFO sees no pop while reset is held,
    // even though the registered counts already read as empty.
    always_comb begin
        pop = rst_n && (state_q == ST_RUN) && !flush && !fifo_empty && room;
    end

    always_comb begin
        buf_nonempty = (occ_q != '0);
        wr_en        = pipe_q[READ_LATENCY-1];
        m_valid      = buf_nonempty && (state_q == ST_RUN);
        rd_en        = m_valid && m_ready;
        // Head comes straight off the buffer read port, masked while empty.
        head         = buf_nonempty ? mem_q[rd_ptr_q] : '0;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        // In-flight valid pipe: pop enters at bit 0, tail is the capture slot.
        pipe_d    = '0;
        pipe_d[0] = pop;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // Circular buffer pointers wrap explicitly so any depth works.
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Late returns keep landing in the buffer until the pipe is
                // empty; then everything is dropped in one step.
                if (inflight == '0) begin
                    state_d  = ST_RUN;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    occ_d    = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
    always_comb begin
        pkt_d = pkt_q;
        if (rd_en && head[DATA_WIDTH]) begin
            pkt_d = pkt_q + PKT_CNT_WIDTH'(1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
            pkt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
            pkt_q    <= pkt_d;
`endif
        end
    end

    // Buffer storage: captured purely by latency position.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= fifo_dout;
        end
    end

    // The slot reservation makes a write into a full buffer impossible.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr_en && (occ_q == OCC_W'(OUT_DEPTH))))
                else $error("ctrl_data_drain: write into full output buffer");
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_shift_out = pop;
        m_ctrl         = head[ENTRY_W-1:DATA_WIDTH];
        m_data         = head[DATA_WIDTH-1:0];
        m_last         = head[DATA_WIDTH];
        occupancy      = occ_q;
        busy           = buf_nonempty || (inflight != '0) || (state_q == ST_FLUSH);
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
        pkt_count      = pkt_q;
`endif
    end

endmodule

// File: tb/tb_ctrl_data_drain.sv
// ---------------------------------------------------------------------------
// tb_ctrl_data_drain
//
// Directed-plus-random bench for ctrl_data_drain. A queue-based FIFO model
// feeds the DUT with the configured read latency (garbage on fifo_dout when
// no pop is returning). The reference model tracks every popped entry with
// the cycle it was popped in; from that it derives when the entry must be
// visible, the expected occupancy, the pop decision and the flush window.
// ---------------------------------------------------------------------------
module tb_ctrl_data_drain;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam int PW = 16;
    localparam int EW = CW + DW;
    localparam int OW = $clog2(D + 1);

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [EW-1:0]   fifo_dout;
    logic            fifo_empty;
    logic            fifo_shift_out;
    logic [CW-1:0]   m_ctrl;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic            m_valid;
    logic            m_ready;
    logic            flush;
    logic [OW-1:0]   occupancy;
    logic            busy;
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
    logic [PW-1:0]   pkt_count;
`endif

    ctrl_data_drain #(
        .DATA_WIDTH   (DW),
        .CTRL_WIDTH   (CW),
        .READ_LATENCY (L),
        .OUT_DEPTH    (D),
        .PKT_CNT_WIDTH(PW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_shift_out(fifo_shift_out),
        .m_ctrl        (m_ctrl),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .flush         (flush),
        .occupancy     (occupancy),
        .busy          (busy)
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    // -----------------------------------------------------------------------
    // Reference model state
    // -----------------------------------------------------------------------
    logic [EW-1:0] fifo_q[$];     // entries still inside the FIFO
    logic [EW-1:0] exp_q[$];      // popped, not yet accepted/discarded
    int            exp_pc_q[$];   // cycle each exp_q entry was popped in
    logic [EW-1:0] lat [L];       // FIFO read-latency line
    int            cyc;
    bit            flush_active;
    logic [PW-1:0] pkt_exp;
    logic [2:0]    last_hist;

    int n_vec;
    int n_err;
    int ph_pops, ph_acc, ph_first, ph_last;

    // -----------------------------------------------------------------------
    // Scoreboard helpers
    // -----------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        fifo_q.push_back({c, d});
        fifo_empty = 1'b0;
    endtask

    task automatic reset_phase();
        ph_pops  = 0;
        ph_acc   = 0;
        ph_first = -1;
        ph_last  = -1;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then
    // advance the model and the FIFO just after the next rising edge.
    task automatic tick();
        int            ready_n;
        int            infl_n;
        logic          exp_valid;
        logic          exp_shift;
        logic          exp_busy;
        logic          acc;
        logic          fl;
        logic [EW-1:0] head;
        logic [EW-1:0] item;

        @(negedge clk);
        ready_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_pc_q[i] + L + 1 <= cyc) ready_n++;
        end
        infl_n    = exp_q.size() - ready_n;
        exp_valid = (ready_n > 0) && !flush_active;
        exp_shift = (fifo_q.size() != 0) && (exp_q.size() < D) && !flush_active && !flush;
        exp_busy  = (exp_q.size() != 0) || flush_active;
        head      = (ready_n > 0) ? exp_q[0] : '0;

        chk("m_valid",   64'(m_valid),        64'(exp_valid));
        chk("shift_out", 64'(fifo_shift_out), 64'(exp_shift));
        chk("occupancy", 64'(occupancy),      64'(ready_n));
        chk("busy",      64'(busy),           64'(exp_busy));
        chk("head",      64'({m_ctrl, m_data}), 64'(head));
        chk("m_last",    64'(m_last),         64'(head[DW]));
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
        chk("pkt_count", 64'(pkt_count),      64'(pkt_exp));
`endif

        acc = exp_valid && m_ready;
        fl  = flush && !flush_active;

        @(posedge clk);
        #1;
        if (acc) begin
            void'(exp_q.pop_front());
            void'(exp_pc_q.pop_front());
            if (head[DW]) pkt_exp = pkt_exp + PW'(1);
            last_hist = {last_hist[1:0], head[DW]};
            ph_acc++;
            if (ph_first < 0) ph_first = cyc;
            ph_last = cyc;
        end
        if (flush_active && infl_n == 0) begin
            exp_q.delete();
            exp_pc_q.delete();
            flush_active = 1'b0;
        end
        if (fl) flush_active = 1'b1;

        item = EW'($urandom);
        if (exp_shift) begin
            item = fifo_q.pop_front();
            exp_q.push_back(item);
            exp_pc_q.push_back(cyc);
            ph_pops++;
        end
        for (int i = L - 1; i > 0; i--) lat[i] = lat[i-1];
        lat[0]     = item;
        fifo_dout  = lat[L-1];
        fifo_empty = (fifo_q.size() == 0);
        flush      = 1'b0;
        cyc++;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !flush_active) break;
            tick();
        end
        chk("drain_done", 64'(exp_q.size() + fifo_q.size()), 64'd0);
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        n_vec        = 0;
        n_err        = 0;
        cyc          = 0;
        flush_active = 1'b0;
        pkt_exp      = '0;
        last_hist    = '0;
        rst_n        = 1'b0;
        m_ready      = 1'b1;
        flush        = 1'b0;
        fifo_dout    = '0;
        fifo_empty   = 1'b1;
        for (int i = 0; i < L; i++) lat[i] = '0;
        reset_phase();

        // Reset state, FIFO preloaded with three entries.
        push(CW'(1), DW'($urandom));
        push(CW'(0), DW'($urandom));
        push(CW'(1), DW'($urandom));
        #3;
        chk("rst_shift",  64'(fifo_shift_out), 64'd0);
        chk("rst_valid",  64'(m_valid),        64'd0);
        chk("rst_last",   64'(m_last),         64'd0);
        chk("rst_occ",    64'(occupancy),      64'd0);
        chk("rst_busy",   64'(busy),           64'd0);
        chk("rst_head",   64'({m_ctrl, m_data}), 64'd0);
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
        chk("rst_pkt",    64'(pkt_count),      64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three back-to-back pops, beats in order with last pattern 1,0,1.
        repeat (8) tick();
        chk("p1_beats", 64'(ph_acc),    64'd3);
        chk("p1_last",  64'(last_hist), 64'b101);
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
        chk("p1_pkt",   64'(pkt_count), 64'd2);
`endif

        // Consumer stalled with ten queued: buffer fills, pops stop.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(CW'($urandom), DW'($urandom));
        reset_phase();
        repeat (25) tick();
        chk("p2_pops", 64'(ph_pops),   64'd4);
        chk("p2_occ",  64'(occupancy), 64'd4);

        // Release: all ten delivered at one beat per cycle.
        m_ready = 1'b1;
        reset_phase();
        for (int i = 0; i < 40; i++) begin
            if (ph_acc >= 10) break;
            tick();
        end
        chk("p3_delivered", 64'(ph_acc),            64'd10);
        chk("p3_rate",      64'(ph_last - ph_first), 64'd9);
        drain();

        // Flush with two buffered and one in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(CW'($urandom), DW'($urandom));
        repeat (4) tick();
        chk("p4_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        reset_phase();
        repeat (4) tick();
        chk("p4_pops", 64'(ph_pops),   64'd0);
        chk("p4_occ",  64'(occupancy), 64'd0);
        m_ready = 1'b1;
        push(CW'($urandom), DW'($urandom));
        reset_phase();
        for (int i = 0; i < 10; i++) begin
            if (ph_acc >= 1) break;
            tick();
        end
        chk("p4_post", 64'(ph_acc), 64'd1);

        // Randomised traffic with random back-pressure and flushes.
        for (int i = 0; i < 300; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 12 && $urandom_range(0, 1) == 1) begin
                push(CW'($urandom), DW'($urandom));
            end
            flush = ($urandom_range(0, 24) == 0);
            tick();
        end
        drain();

        // Asynchronous reset with three buffered entries.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(CW'($urandom), DW'($urandom));
        repeat (6) tick();
        chk("p6_pre_occ", 64'(occupancy), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("p6_valid", 64'(m_valid),        64'd0);
        chk("p6_occ",   64'(occupancy),      64'd0);
        chk("p6_busy",  64'(busy),           64'd0);
        chk("p6_shift", 64'(fifo_shift_out), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        exp_pc_q.delete();
        flush_active = 1'b0;
        pkt_exp      = '0;
        fifo_empty   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("p6_head", 64'({m_ctrl, m_data}), 64'd0);
`ifdef CTRL_DATA_DRAIN_PKT_CNT_EN
        chk("p6_pkt",  64'(pkt_count), 64'd0);
`endif

        // Empty FIFO for 50 cycles: no pops, idle.
        m_ready = 1'b1;
        reset_phase();
        repeat (50) tick();
        chk("p7_pops", 64'(ph_pops), 64'd0);
        chk("p7_busy", 64'(busy),    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
